// File: rtl/store_packer.sv
// Store-side packer: narrows and lane-replicates store data, generates byte enables,
// and queues packed stores in a small FIFO. Misaligned and illegal-size stores are dropped and flagged.
module store_packer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [31:0]             in_data,
  input  logic [1:0]              in_size,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [31:0]             out_data,
  output logic [3:0]              out_be,
  output logic                    misalign,
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  function automatic logic [31:0] pack_data(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'd0:    pack_data = {4{d[7:0]}};
      2'd1:    pack_data = {2{d[15:0]}};
      2'd2:    pack_data = d;
      default: pack_data = 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] pack_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    pack_be = 4'b0001 << a;
      2'd1:    pack_be = a[1] ? 4'b1100 : 4'b0011;
      2'd2:    pack_be = 4'b1111;
      default: pack_be = 4'b0000;
    endcase
  endfunction

  function automatic logic is_bad(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    is_bad = 1'b0;
      2'd1:    is_bad = a[0];
      2'd2:    is_bad = (a != 2'b00);
      default: is_bad = 1'b1;
    endcase
  endfunction

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [31:0]           mem_data [DEPTH];
  logic [3:0]            mem_be   [DEPTH];

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  misalign_p1;
  logic [ADDR_WIDTH-1:0] err_addr_p1;

  logic                  acc_p0, bad_p0, push_p0, pop_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [31:0]           data_p0;
  logic [3:0]            be_p0;

  // Stage 0: accept, classify and pack the incoming request
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign acc_p0    = in_valid && in_ready;
  assign bad_p0    = is_bad(in_size, in_addr[1:0]);
  assign push_p0   = acc_p0 && !bad_p0;
  assign pop_p0    = out_valid && out_ready;
  assign addr_p0   = {in_addr[ADDR_WIDTH-1:2], 2'b00};
  assign data_p0   = pack_data(in_data, in_size);
  assign be_p0     = pack_be(in_size, in_addr[1:0]);

  always_ff @(posedge clk) begin
    if (push_p0) begin
      mem_addr[wr_ptr] <= addr_p0;
      mem_data[wr_ptr] <= data_p0;
      mem_be[wr_ptr]   <= be_p0;
    end
  end

  // Stage 1: FIFO bookkeeping and error reporting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      misalign_p1 <= 1'b0;
      err_addr_p1 <= '0;
    end else begin
      if (push_p0) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_p0)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_p0, pop_p0})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      misalign_p1 <= acc_p0 && bad_p0;
      if (acc_p0 && bad_p0) err_addr_p1 <= in_addr;
    end
  end

  // Head entry is only presented while valid so stale storage never leaks out
  assign out_addr = out_valid ? mem_addr[rd_ptr] : '0;
  assign out_data = out_valid ? mem_data[rd_ptr] : '0;
  assign out_be   = out_valid ? mem_be[rd_ptr]   : '0;
  assign misalign = misalign_p1;
  assign err_addr = err_addr_p1;
  assign count    = count_q;

endmodule

// File: tb/tb_store_packer.sv
// Directed bench for store_packer: packing, rejection, fill/stall, streaming and reset.
module tb_store_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        misalign;
  logic [31:0] err_addr;
  logic [1:0]  count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  store_packer #(.ADDR_WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_size(in_size),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_be(out_be),
    .misalign(misalign), .err_addr(err_addr), .count(count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    in_valid = v; in_addr = a; in_data = d; in_size = s;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    out_ready = 1'b0;
    reset_n = 1'b0;
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 2'd0 || misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got valid=%b ready=%b count=%0d mis=%b, need 0 1 0 0", out_valid, in_ready, count, misalign);
    end
    vectors++;
    if (err_addr !== 32'h0 || out_addr !== 32'h0 || out_data !== 32'h0 || out_be !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_data: got err=%h addr=%h data=%h be=%b, need all 0", err_addr, out_addr, out_data, out_be);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_pack();
    logic [31:0] a_in [5] = '{32'h1003, 32'h2002, 32'h2000, 32'h0010, 32'h0021};
    logic [31:0] d_in [5] = '{32'hAABBCCDD, 32'h12345678, 32'h12345678, 32'hCAFEF00D, 32'h00000011};
    logic [1:0]  s_in [5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
    logic [31:0] a_ex [5] = '{32'h1000, 32'h2000, 32'h2000, 32'h0010, 32'h0020};
    logic [31:0] d_ex [5] = '{32'hDDDDDDDD, 32'h56785678, 32'h56785678, 32'hCAFEF00D, 32'h11111111};
    logic [3:0]  b_ex [5] = '{4'b1000, 4'b1100, 4'b0011, 4'b1111, 4'b0010};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, a_in[i], d_in[i], s_in[i]);
      tick();
      drive(1'b0, 32'h0, 32'h0, 2'd0);
      vectors++;
      if (out_valid !== 1'b1 || count !== 2'd1 || out_addr !== a_ex[i] || out_data !== d_ex[i] || out_be !== b_ex[i]) begin
        miscompares++;
        $display("FAIL pack[%0d]: got v=%b cnt=%0d addr=%h data=%h be=%b, need 1 1 %h %h %b",
                 i, out_valid, count, out_addr, out_data, out_be, a_ex[i], d_ex[i], b_ex[i]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || count !== 2'd0 || out_be !== 4'b0000) begin
        miscompares++;
        $display("FAIL pack_pop[%0d]: got v=%b cnt=%0d be=%b, need 0 0 0000", i, out_valid, count, out_be);
      end
    end
  endtask

  task automatic test_misalign();
    out_ready = 1'b0;
    drive(1'b1, 32'h3001, 32'h11223344, 2'd2);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mis_ready: got %b need 1", in_ready);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    vectors++;
    if (misalign !== 1'b1 || err_addr !== 32'h3001 || count !== 2'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mis_pulse: got mis=%b err=%h cnt=%0d v=%b, need 1 3001 0 0", misalign, err_addr, count, out_valid);
    end
    tick();
    vectors++;
    if (misalign !== 1'b0 || err_addr !== 32'h3001) begin
      miscompares++;
      $display("FAIL mis_hold: got mis=%b err=%h, need 0 3001", misalign, err_addr);
    end
    // back-to-back errors: misaligned half then illegal size
    drive(1'b1, 32'h4001, 32'h0, 2'd1);
    tick();
    vectors++;
    if (misalign !== 1'b1 || err_addr !== 32'h4001) begin
      miscompares++;
      $display("FAIL b2b_err1: got mis=%b err=%h, need 1 4001", misalign, err_addr);
    end
    drive(1'b1, 32'h5000, 32'h0, 2'd3);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    vectors++;
    if (misalign !== 1'b1 || err_addr !== 32'h5000 || count !== 2'd0) begin
      miscompares++;
      $display("FAIL b2b_err2: got mis=%b err=%h cnt=%0d, need 1 5000 0", misalign, err_addr, count);
    end
    tick();
    vectors++;
    if (misalign !== 1'b0 || err_addr !== 32'h5000) begin
      miscompares++;
      $display("FAIL b2b_end: got mis=%b err=%h, need 0 5000", misalign, err_addr);
    end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    drive(1'b1, 32'h100, 32'h1, 2'd2);
    tick();
    vectors++;
    if (count !== 2'd1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fill1: got cnt=%0d rdy=%b, need 1 1", count, in_ready);
    end
    drive(1'b1, 32'h104, 32'h2, 2'd2);
    tick();
    vectors++;
    if (count !== 2'd2 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill2: got cnt=%0d rdy=%b, need 2 0", count, in_ready);
    end
    drive(1'b1, 32'h108, 32'h3, 2'd2);
    out_ready = 1'b1;  // full FIFO must still refuse the third store this cycle
    tick();
    vectors++;
    if (count !== 2'd1 || in_ready !== 1'b1 || out_addr !== 32'h104 || out_data !== 32'h2) begin
      miscompares++;
      $display("FAIL fill_pop1: got cnt=%0d rdy=%b addr=%h data=%h, need 1 1 104 2", count, in_ready, out_addr, out_data);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    vectors++;
    if (count !== 2'd1 || out_addr !== 32'h108 || out_data !== 32'h3) begin
      miscompares++;
      $display("FAIL fill_pop2: got cnt=%0d addr=%h data=%h, need 1 108 3", count, out_addr, out_data);
    end
    tick();
    vectors++;
    if (count !== 2'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_empty: got cnt=%0d v=%b, need 0 0", count, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall_hold();
    out_ready = 1'b0;
    drive(1'b1, 32'h200, 32'hA5, 2'd2);
    tick();
    drive(1'b1, 32'h204, 32'hB6, 2'd2);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_addr !== 32'h200 || out_data !== 32'hA5 || count !== 2'd2 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold[%0d]: got v=%b addr=%h data=%h cnt=%0d rdy=%b, need 1 200 a5 2 0", k, out_valid, out_addr, out_data, count, in_ready);
      end
    end
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    vectors++;
    if (count !== 2'd0) begin
      miscompares++;
      $display("FAIL hold_drain: got cnt=%0d need 0", count);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h400 + 32'(k * 4), 32'hA0 + 32'(k), 2'd2);
      tick();
      vectors++;
      if (count !== 2'd1 || out_valid !== 1'b1 || out_addr !== 32'h400 + 32'(k * 4) || out_data !== 32'hA0 + 32'(k)) begin
        miscompares++;
        $display("FAIL stream[%0d]: got cnt=%0d v=%b addr=%h data=%h, need 1 1 %h %h",
                 k, count, out_valid, out_addr, out_data, 32'h400 + 32'(k * 4), 32'hA0 + 32'(k));
      end
    end
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    tick();
    vectors++;
    if (count !== 2'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_end: got cnt=%0d v=%b, need 0 0", count, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 32'h600, 32'h1, 2'd2);
    tick();
    drive(1'b1, 32'h604, 32'h2, 2'd2);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    vectors++;
    if (count !== 2'd2) begin
      miscompares++;
      $display("FAIL rmid_pre: got cnt=%0d need 2", count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || count !== 2'd0 || misalign !== 1'b0 || in_ready !== 1'b1 || err_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL rmid_async: got v=%b cnt=%0d mis=%b rdy=%b err=%h, need 0 0 0 1 0", out_valid, count, misalign, in_ready, err_addr);
    end
    tick();
    reset_n = 1'b1;
    tick();
    drive(1'b1, 32'h7002, 32'h0000BEEF, 2'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    vectors++;
    if (out_valid !== 1'b1 || count !== 2'd1 || out_addr !== 32'h7000 || out_data !== 32'hBEEFBEEF || out_be !== 4'b1100) begin
      miscompares++;
      $display("FAIL rmid_after: got v=%b cnt=%0d addr=%h data=%h be=%b, need 1 1 7000 beefbeef 1100",
               out_valid, count, out_addr, out_data, out_be);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    test_reset();
    test_pack();
    test_misalign();
    test_fill();
    test_stall_hold();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
